// File: rtl/add4_share_sched.sv
// rtl/add4_share_sched.sv - two-requester round-robin sequencer around one shared adder
module add4_share_sched #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  input  logic             rsp_ready,
  output logic             busy,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             w_gnt0;
  logic             w_gnt1;
  logic             r_last_gnt;
  logic             r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH:0]   w_full;
  logic             w_ovf;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_carry;
  logic             r_rsp_ovf;
  logic [7:0]       r_op_count;

  // The only driver of the shared adder: operands come from the latched request.
  assign w_full = {1'b0, r_a} + {1'b0, r_b};
  assign w_ovf  = (r_a[WIDTH-1] == r_b[WIDTH-1]) & (w_full[WIDTH-1] != r_a[WIDTH-1]);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and round-robin grant; grants are gated by rst so they drop immediately on reset.
  always_comb begin
    w_next = r_state;
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst) begin
          w_gnt0 = req0_valid & (~req1_valid | r_last_gnt);
          w_gnt1 = req1_valid & (~req0_valid | ~r_last_gnt);
        end
        if (w_gnt0 | w_gnt1) begin
          w_next = S_CALC;
        end
      end
      S_CALC: w_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture on accept; last_gnt starts at 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a        <= '0;
      r_b        <= '0;
      r_id       <= 1'b0;
      r_last_gnt <= 1'b1;
    end else if (w_gnt0 | w_gnt1) begin
      r_a        <= w_gnt1 ? req1_a : req0_a;
      r_b        <= w_gnt1 ? req1_b : req0_b;
      r_id       <= w_gnt1;
      r_last_gnt <= w_gnt1;
    end
  end

  // Result registers load only in CALC, so they hold steady through RESP backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_id    <= 1'b0;
      r_rsp_sum   <= '0;
      r_rsp_carry <= 1'b0;
      r_rsp_ovf   <= 1'b0;
    end else if (r_state == S_CALC) begin
      r_rsp_id    <= r_id;
      r_rsp_sum   <= w_full[WIDTH-1:0];
      r_rsp_carry <= w_full[WIDTH];
      r_rsp_ovf   <= w_ovf;
    end
  end

  // Completed-response counter, wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op_count <= 8'd0;
    end else if ((r_state == S_RESP) && rsp_ready) begin
      r_op_count <= r_op_count + 8'd1;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp_valid  = (r_state == S_RESP);
  assign busy       = (r_state != S_IDLE);
  assign rsp_id     = r_rsp_id;
  assign rsp_sum    = r_rsp_sum;
  assign rsp_carry  = r_rsp_carry;
  assign rsp_ovf    = r_rsp_ovf;
  assign op_count   = r_op_count;

endmodule

// File: tb/tb_add4_share_sched.sv
// tb/tb_add4_share_sched.sv - self-checking bench for add4_share_sched
module tb_add4_share_sched;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_id, rsp_carry, rsp_ovf, rsp_ready, busy;
  logic [W-1:0] rsp_sum;
  logic [7:0]   op_count;

  int checks   = 0;
  int failures = 0;
  int m_last   = 1;
  int m_count  = 0;

  add4_share_sched #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
    .rsp_ovf(rsp_ovf), .rsp_ready(rsp_ready), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_sum"}, rsp_sum, 0);
    chk({tag, "_rsp_carry"}, rsp_carry, 0);
    chk({tag, "_rsp_ovf"}, rsp_ovf, 0);
    chk({tag, "_ready0"}, req0_ready, 0);
    chk({tag, "_ready1"}, req1_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_op_count"}, op_count, 0);
  endtask

  // One full operation from an IDLE negedge back to the following IDLE negedge.
  task automatic op(input string tag, input bit v0, input int a0, input int b0,
                    input bit v1, input int a1, input int b1, input int bp);
    int g, ea, eb, s, sa, sb, ss;
    bit eovf;
    req0_valid = v0; req0_a = a0[W-1:0]; req0_b = b0[W-1:0];
    req1_valid = v1; req1_a = a1[W-1:0]; req1_b = b1[W-1:0];
    #1;
    if (v0 && v1) g = (m_last == 1) ? 0 : 1;
    else          g = v0 ? 0 : 1;
    chk({tag, "_gnt0"}, req0_ready, (g == 0));
    chk({tag, "_gnt1"}, req1_ready, (g == 1));
    m_last = g;
    ea = (g == 1) ? a1 : a0;
    eb = (g == 1) ? b1 : b0;
    s  = ea + eb;
    sa = (ea >= 8) ? ea - 16 : ea;
    sb = (eb >= 8) ? eb - 16 : eb;
    ss = sa + sb;
    eovf = (ss > 7) || (ss < -8);
    @(posedge clk); @(negedge clk);
    chk({tag, "_calc_busy"}, busy, 1);
    chk({tag, "_calc_valid"}, rsp_valid, 0);
    chk({tag, "_calc_rdy"}, {req0_ready, req1_ready}, 0);
    rsp_ready = (bp == 0);
    @(posedge clk); @(negedge clk);
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, g);
    chk({tag, "_sum"}, rsp_sum, s % 16);
    chk({tag, "_carry"}, rsp_carry, s / 16);
    chk({tag, "_ovf"}, rsp_ovf, eovf);
    for (int i = 0; i < bp; i++) begin
      chk({tag, "_bp_rdy"}, {req0_ready, req1_ready}, 0);
      chk({tag, "_bp_busy"}, busy, 1);
      @(posedge clk); @(negedge clk);
      chk({tag, "_bp_valid"}, rsp_valid, 1);
      chk({tag, "_bp_hold"}, {rsp_id, rsp_carry, rsp_ovf, rsp_sum}, {g[0], s >= 16, eovf, 4'(s % 16)});
      chk({tag, "_bp_count"}, op_count, m_count);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    m_count = (m_count + 1) % 256;
    chk({tag, "_count"}, op_count, m_count);
    chk({tag, "_idle_busy"}, busy, 0);
    chk({tag, "_idle_valid"}, rsp_valid, 0);
    chk({tag, "_idle_sum"}, rsp_sum, s % 16);
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'd3; req0_b = 4'd3;
    req1_valid = 1'b0; req1_a = 4'd0; req1_b = 4'd0;
    #2;
    chk_all_zero("reset");
    @(negedge clk); @(negedge clk);
    req0_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("rel_busy", busy, 0);
    chk("rel_count", op_count, 0);

    op("single", 1, 8, 8, 0, 0, 0, 0);
    op("carry", 0, 0, 0, 1, 9, 7, 0);
    for (int k = 0; k < 4; k++) op("rr", 1, 3, 4, 1, 5, 6, 0);
    op("bp", 1, 2, 7, 0, 0, 0, 5);

    // Reset during CALC discards the pending operation.
    req0_valid = 1'b1; req0_a = 4'd1; req0_b = 4'd2; req1_valid = 1'b1;
    @(posedge clk); #2;
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk_all_zero("midcalc");
    @(negedge clk);
    rst = 1'b0;
    m_last = 1; m_count = 0;
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", op_count, 0);
    op("tie_after_rst", 1, 1, 1, 1, 2, 2, 0);

    for (int n = 0; n < 256; n++) begin
      int pat;
      pat = $urandom_range(1, 3);
      op("rand", pat[0], $urandom_range(0, 15), $urandom_range(0, 15),
         pat[1], $urandom_range(0, 15), $urandom_range(0, 15),
         ($urandom_range(0, 7) == 0) ? 2 : 0);
      if (n == 254) chk("wrap_zero", op_count, 0);
    end
    chk("wrap_one", op_count, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
